// File: rtl/vdp_io_pkg.sv
// vdp_io_pkg
//   Shared types and defaults for the CPU-to-VDP write-posting buffer.
//   - vdp_io_state_t : transfer sequencer states (IDLE, XFER, GAP)
//   - vdp_io_entry_t : one queued write, {port, data}. The port field is
//                      sized for the widest supported port select. A
//                      narrower PORT_W is zero-extended into it.
//   - VDP_IO_DEPTH / VDP_IO_PORT_W : default block parameters
package vdp_io_pkg;

  localparam int VDP_IO_DEPTH    = 16;
  localparam int VDP_IO_PORT_W   = 2;
  // Widest port select the entry struct can carry (PORT_W must not exceed it).
  localparam int VDP_IO_PORT_MAX = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    GAP  = 2'd2
  } vdp_io_state_t;

  typedef struct packed {
    logic [VDP_IO_PORT_MAX-1:0] port;
    logic [7:0]                 data;
  } vdp_io_entry_t;

  // Builds an entry from a zero-extended port number and a data byte.
  function automatic vdp_io_entry_t make_entry(
    input logic [VDP_IO_PORT_MAX-1:0] port,
    input logic [7:0]                 data
  );
    vdp_io_entry_t e;
    e.port = port;
    e.data = data;
    return e;
  endfunction

endpackage

// File: rtl/vdp_io_fifo_sync_fifo.sv
// sync_fifo
//   Generic single-clock FIFO with an occupancy counter.
//   Parameters:
//     WIDTH : entry width in bits
//     DEPTH : number of entries (power of 2, >= 2)
//   Ports:
//     clk, reset : clock, synchronous active-high reset
//     push, din  : write strobe and data. A push into a full FIFO is
//                  accepted only when a pop happens in the same cycle.
//     pop        : removes the head entry (ignored when empty)
//     dout       : current head entry (combinational view of the storage)
//     full, empty: occupancy flags
//     level      : number of stored entries, 0..DEPTH
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [LW-1:0]    count_reg;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count_reg == '0);
  assign full    = (count_reg == LW'(DEPTH));
  assign do_pop  = pop & ~empty;
  // A pop in the same cycle frees the slot the push is about to use.
  assign do_push = push & (~full | do_pop);

  // Pointers are exactly AW bits wide, so the increment wraps modulo DEPTH.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_reg <= wr_ptr_reg + AW'(1);
      end
      if (do_pop) begin
        rd_ptr_reg <= rd_ptr_reg + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + LW'(1);
        2'b01:   count_reg <= count_reg - LW'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Storage carries no reset; only the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_reg] <= din;
    end
  end

  // The head is read combinationally so the sequencer can present it on the
  // first request cycle. The storage is small enough for distributed RAM.
  assign dout  = mem[rd_ptr_reg];
  assign level = count_reg;

endmodule

// File: rtl/vdp_io_fifo.sv
// vdp_io_fifo
//   Write-posting buffer between the CPU I/O port and the VDP core. CPU
//   writes are queued and replayed to the VDP over a REQ/ACK handshake. A
//   read is held in a single pending slot and is issued only after every
//   write queued before it has been delivered.
//   Parameters:
//     DEPTH  : queued write entries (power of 2, >= 2)
//     PORT_W : VDP port-select width (<= 8)
//   Ports:
//     clk, reset             : clock, synchronous active-high reset
//     cpu_req/cpu_wr         : single-cycle access strobe, 1 = write
//     cpu_port/cpu_wdata     : access port and write data
//     cpu_rdata/cpu_rvalid   : last read result, one-cycle update pulse
//     cpu_wait               : FIFO full or read pending
//     vdp_req/vdp_wr         : VDP request and write qualifier
//     vdp_port/vdp_wdata     : current transfer port and write data
//     vdp_rdata/vdp_ack      : VDP read data and acknowledge
//     level                  : FIFO occupancy
//     overflow               : sticky drop indicator, cleared by reset
module vdp_io_fifo
  import vdp_io_pkg::*;
#(
  parameter int DEPTH  = VDP_IO_DEPTH,
  parameter int PORT_W = VDP_IO_PORT_W
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   cpu_req,
  input  logic                   cpu_wr,
  input  logic [PORT_W-1:0]      cpu_port,
  input  logic [7:0]             cpu_wdata,
  output logic [7:0]             cpu_rdata,
  output logic                   cpu_rvalid,
  output logic                   cpu_wait,
  output logic                   vdp_req,
  output logic                   vdp_wr,
  output logic [PORT_W-1:0]      vdp_port,
  output logic [7:0]             vdp_wdata,
  input  logic [7:0]             vdp_rdata,
  input  logic                   vdp_ack,
  output logic [$clog2(DEPTH):0] level,
  output logic                   overflow
);

  localparam int CNT_W   = $clog2(DEPTH) + 1;
  localparam int ENTRY_W = PORT_W + 8;

  // ---------------------------------------------------------------------
  // Write queue
  // ---------------------------------------------------------------------
  logic               push_en;
  logic               pop_en;
  logic               fifo_full;
  logic               fifo_empty;
  logic [CNT_W-1:0]   fifo_level;
  logic [ENTRY_W-1:0] fifo_din;
  logic [ENTRY_W-1:0] fifo_dout;
  vdp_io_entry_t      head;
  logic               unused_head_port;

  assign fifo_din = {cpu_port, cpu_wdata};

  sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push_en),
    .pop   (pop_en),
    .din   (fifo_din),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  assign head = make_entry(VDP_IO_PORT_MAX'(fifo_dout[ENTRY_W-1:8]), fifo_dout[7:0]);
  // Bits above PORT_W are always zero after the zero-extension above.
  assign unused_head_port = |(head.port >> PORT_W);

  // ---------------------------------------------------------------------
  // Request decode and handshake events
  // ---------------------------------------------------------------------
  vdp_io_state_t     state_reg;
  vdp_io_state_t     state_next;
  logic              xfer_wr_reg;
  logic              rd_pend_reg;
  logic [PORT_W-1:0] rd_port_reg;
  logic [CNT_W-1:0]  wr_before_rd_reg;
  logic [7:0]        cpu_rdata_reg;
  logic              cpu_rvalid_reg;
  logic              overflow_reg;

  logic              wr_req;
  logic              rd_req;
  logic              ack_now;
  logic              rd_capture;
  logic              rd_drop;
  logic              wr_drop;
  logic              rd_done;
  logic [CNT_W-1:0]  level_next;
  logic              wr_avail;
  logic              wr_first;
  logic              issue_wr;
  logic              issue_rd;

  assign wr_req     = cpu_req & cpu_wr;
  assign rd_req     = cpu_req & ~cpu_wr;
  // Acknowledge only counts while a request is actually outstanding.
  assign ack_now    = (state_reg == XFER) & vdp_ack;
  assign pop_en     = ack_now & xfer_wr_reg;
  assign rd_done    = ack_now & ~xfer_wr_reg;
  assign push_en    = wr_req & (~fifo_full | pop_en);
  assign wr_drop    = wr_req & ~push_en;
  assign rd_capture = rd_req & ~rd_pend_reg;
  assign rd_drop    = rd_req & rd_pend_reg;
  assign level_next = fifo_level + CNT_W'(push_en) - CNT_W'(pop_en);

  // A write is available if something is queued or is being queued right
  // now; the latter lets an idle block raise the request one cycle after
  // the CPU strobe.
  assign wr_avail = ~fifo_empty | push_en;
  // With a read pending, the oldest write goes first only while writes
  // older than the read remain. A read captured in this very cycle latches
  // the current level, so when not yet pending every queued write is older.
  assign wr_first = rd_pend_reg ? (wr_before_rd_reg != '0) : 1'b1;

  // ---------------------------------------------------------------------
  // Transfer sequencer
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    issue_wr   = 1'b0;
    issue_rd   = 1'b0;
    case (state_reg)
      IDLE: begin
        if (wr_avail && wr_first) begin
          issue_wr   = 1'b1;
          state_next = XFER;
        end else if (rd_pend_reg || rd_capture) begin
          issue_rd   = 1'b1;
          state_next = XFER;
        end
      end
      XFER: begin
        if (vdp_ack) begin
          state_next = GAP;
        end
      end
      GAP: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------
  // Transfer kind, pending read, ordering counter, CPU-side results
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      xfer_wr_reg      <= 1'b0;
      rd_pend_reg      <= 1'b0;
      rd_port_reg      <= '0;
      wr_before_rd_reg <= '0;
      cpu_rdata_reg    <= 8'h00;
      cpu_rvalid_reg   <= 1'b0;
      overflow_reg     <= 1'b0;
    end else begin
      if (issue_wr) begin
        xfer_wr_reg <= 1'b1;
      end else if (issue_rd) begin
        xfer_wr_reg <= 1'b0;
      end

      if (rd_capture) begin
        rd_pend_reg <= 1'b1;
        rd_port_reg <= cpu_port;
      end else if (rd_done) begin
        rd_pend_reg <= 1'b0;
      end

      // Count of writes that must reach the VDP before the pending read.
      if (rd_capture) begin
        wr_before_rd_reg <= level_next;
      end else if (pop_en && wr_before_rd_reg != '0) begin
        wr_before_rd_reg <= wr_before_rd_reg - CNT_W'(1);
      end

      cpu_rvalid_reg <= rd_done;
      if (rd_done) begin
        cpu_rdata_reg <= vdp_rdata;
      end

      overflow_reg <= overflow_reg | wr_drop | rd_drop;
    end
  end

  // ---------------------------------------------------------------------
  // Outputs. Transfer fields are forced to zero outside XFER so nothing
  // from uninitialised storage is visible after reset.
  // ---------------------------------------------------------------------
  always_comb begin
    vdp_req   = (state_reg == XFER);
    vdp_wr    = 1'b0;
    vdp_port  = '0;
    vdp_wdata = 8'h00;
    if (state_reg == XFER) begin
      if (xfer_wr_reg) begin
        vdp_wr    = 1'b1;
        vdp_port  = head.port[PORT_W-1:0];
        vdp_wdata = head.data;
      end else begin
        vdp_port  = rd_port_reg;
      end
    end
  end

  assign cpu_rdata  = cpu_rdata_reg;
  assign cpu_rvalid = cpu_rvalid_reg;
  assign cpu_wait   = (fifo_level == CNT_W'(DEPTH)) | rd_pend_reg;
  assign level      = fifo_level;
  assign overflow   = overflow_reg;

endmodule

// File: tb/tb_vdp_io_fifo.sv
module tb_vdp_io_fifo;

  localparam int DEPTH  = 16;
  localparam int PORT_W = 2;
  localparam int LW     = 5;

  logic              clk = 1'b0;
  logic              reset;
  logic              cpu_req;
  logic              cpu_wr;
  logic [PORT_W-1:0] cpu_port;
  logic [7:0]        cpu_wdata;
  logic [7:0]        cpu_rdata;
  logic              cpu_rvalid;
  logic              cpu_wait;
  logic              vdp_req;
  logic              vdp_wr;
  logic [PORT_W-1:0] vdp_port;
  logic [7:0]        vdp_wdata;
  logic [7:0]        vdp_rdata;
  logic              vdp_ack;
  logic [LW-1:0]     level;
  logic              overflow;

  vdp_io_fifo #(.DEPTH(DEPTH), .PORT_W(PORT_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .cpu_req    (cpu_req),
    .cpu_wr     (cpu_wr),
    .cpu_port   (cpu_port),
    .cpu_wdata  (cpu_wdata),
    .cpu_rdata  (cpu_rdata),
    .cpu_rvalid (cpu_rvalid),
    .cpu_wait   (cpu_wait),
    .vdp_req    (vdp_req),
    .vdp_wr     (vdp_wr),
    .vdp_port   (vdp_port),
    .vdp_wdata  (vdp_wdata),
    .vdp_rdata  (vdp_rdata),
    .vdp_ack    (vdp_ack),
    .level      (level),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  // Reference model: accepted CPU operations in program order. The VDP must
  // see exactly this sequence; writes occupy the queue until acknowledged.
  typedef struct {
    bit         is_wr;
    logic [1:0] port;
    logic [7:0] data;
  } op_t;

  op_t        q[$];
  int         m_level;
  bit         m_rd_pend;
  bit         m_ovf;
  logic [7:0] m_rdata;
  int         tests;
  int         fails;
  int         cycle_cnt;

  task automatic model_clear();
    q.delete();
    m_level   = 0;
    m_rd_pend = 0;
    m_ovf     = 0;
    m_rdata   = 8'h00;
  endtask

  // One clock cycle: the bench acts as the VDP (ack/rdata) and the CPU
  // (one optional request), advances the model, then checks the DUT.
  task automatic tick(input bit req, input bit wr, input logic [1:0] port,
                      input logic [7:0] wdata, input bit ack, input logic [7:0] rdat);
    op_t h;
    bit  popped_wr;
    bit  exp_rv;
    bit  exp_wait;
    int  lvl0;
    bit  rdp0;
    cpu_req   = req;
    cpu_wr    = wr;
    cpu_port  = port;
    cpu_wdata = wdata;
    vdp_ack   = ack;
    vdp_rdata = rdat;
    lvl0      = m_level;
    rdp0      = m_rd_pend;
    popped_wr = 0;
    exp_rv    = 0;
    if (ack && vdp_req) begin
      tests++;
      if (q.size() == 0) begin
        fails++;
        $display("[TB] FAIL xfer_unexpected: vdp_req with nothing accepted, wr=%0b port=%0d", vdp_wr, vdp_port);
      end else begin
        h = q.pop_front();
        if (vdp_wr !== h.is_wr || vdp_port !== h.port || (h.is_wr && vdp_wdata !== h.data)) begin
          fails++;
          $display("[TB] FAIL xfer_content: got wr=%0b port=%0d data=%02h, expected wr=%0b port=%0d data=%02h",
                   vdp_wr, vdp_port, vdp_wdata, h.is_wr, h.port, h.data);
        end
        $display("[TB] cyc %0d xfer %s port=%0d data=%02h", cycle_cnt, h.is_wr ? "WR" : "RD",
                 h.port, h.is_wr ? h.data : rdat);
        if (h.is_wr) begin
          popped_wr = 1;
          m_level--;
        end else begin
          exp_rv    = 1;
          m_rd_pend = 0;
          m_rdata   = rdat;
        end
      end
    end
    if (req && wr) begin
      if (lvl0 < DEPTH || popped_wr) begin
        q.push_back('{1'b1, port, wdata});
        m_level++;
      end else begin
        m_ovf = 1;
      end
    end else if (req) begin
      if (!rdp0) begin
        q.push_back('{1'b0, port, 8'h00});
        m_rd_pend = 1;
      end else begin
        m_ovf = 1;
      end
    end
    @(posedge clk);
    #1;
    cpu_req = 1'b0;
    vdp_ack = 1'b0;
    cycle_cnt++;
    exp_wait = (m_level == DEPTH) || m_rd_pend;
    tests++;
    if (level !== LW'(m_level)) begin
      fails++;
      $display("[TB] FAIL level: got %0d expected %0d", level, m_level);
    end
    tests++;
    if (overflow !== m_ovf) begin
      fails++;
      $display("[TB] FAIL overflow: got %0b expected %0b", overflow, m_ovf);
    end
    tests++;
    if (cpu_wait !== exp_wait) begin
      fails++;
      $display("[TB] FAIL cpu_wait: got %0b expected %0b", cpu_wait, exp_wait);
    end
    tests++;
    if (cpu_rvalid !== exp_rv) begin
      fails++;
      $display("[TB] FAIL cpu_rvalid: got %0b expected %0b", cpu_rvalid, exp_rv);
    end
    tests++;
    if (cpu_rdata !== m_rdata) begin
      fails++;
      $display("[TB] FAIL cpu_rdata: got %02h expected %02h", cpu_rdata, m_rdata);
    end
    tests++;
    if (vdp_req === 1'b1 && q.size() == 0) begin
      fails++;
      $display("[TB] FAIL spurious_req: got vdp_req=1 expected 0 (nothing outstanding)");
    end
  endtask

  // Idle CPU, VDP acknowledges every request; returns rvalid pulses seen.
  task automatic drain(input int budget, input logic [7:0] rdat, output int rv_cnt);
    int n;
    rv_cnt = 0;
    n = 0;
    while ((q.size() != 0 || vdp_req === 1'b1) && n < budget) begin
      tick(0, 0, 2'd0, 8'h00, vdp_req, rdat);
      if (cpu_rvalid === 1'b1) rv_cnt++;
      n++;
    end
    tests++;
    if (n >= budget) begin
      fails++;
      $display("[TB] FAIL drain_timeout: got %0d ops left expected 0", q.size());
    end
    repeat (3) begin
      tick(0, 0, 2'd0, 8'h00, 1'b0, 8'h00);
      if (cpu_rvalid === 1'b1) rv_cnt++;
    end
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    cpu_req   = 1'b0;
    cpu_wr    = 1'b0;
    cpu_port  = '0;
    cpu_wdata = 8'h00;
    vdp_ack   = 1'b0;
    vdp_rdata = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    model_clear();
  endtask

  task automatic test_reset();
    do_reset();
    tests++;
    if ({vdp_req, vdp_wr, vdp_port, vdp_wdata, cpu_rvalid, cpu_wait, overflow} !== '0
        || cpu_rdata !== 8'h00 || level !== '0) begin
      fails++;
      $display("[TB] FAIL reset_outputs: got req=%0b wr=%0b port=%0d wd=%02h rv=%0b wait=%0b ovf=%0b rd=%02h lvl=%0d expected all 0",
               vdp_req, vdp_wr, vdp_port, vdp_wdata, cpu_rvalid, cpu_wait, overflow, cpu_rdata, level);
    end
    repeat (3) tick(0, 0, 2'd0, 8'h00, 1'b0, 8'h00);
  endtask

  task automatic test_single_write();
    int rv;
    do_reset();
    tick(1, 1, 2'd1, 8'hA5, 1'b0, 8'h00);
    tests++;
    if (vdp_req !== 1'b1 || vdp_wr !== 1'b1 || vdp_port !== 2'd1 || vdp_wdata !== 8'hA5) begin
      fails++;
      $display("[TB] FAIL write_latency: got req=%0b wr=%0b port=%0d data=%02h expected 1 1 1 a5",
               vdp_req, vdp_wr, vdp_port, vdp_wdata);
    end
    tick(0, 0, 2'd0, 8'h00, 1'b0, 8'h00);
    tick(0, 0, 2'd0, 8'h00, 1'b1, 8'h00);
    tests++;
    if (vdp_req !== 1'b0 || level !== '0) begin
      fails++;
      $display("[TB] FAIL write_release: got req=%0b level=%0d expected 0 0", vdp_req, level);
    end
    drain(20, 8'h00, rv);
  endtask

  task automatic fill(input int n, input logic [7:0] base);
    for (int i = 0; i < n; i++) begin
      tick(1, 1, 2'(i), base + 8'(i), 1'b0, 8'h00);
    end
  endtask

  task automatic test_fill_overflow();
    int  ack_cyc[$];
    int  n;
    bit  a;
    do_reset();
    fill(16, 8'h40);
    tests++;
    if (level !== LW'(16) || cpu_wait !== 1'b1 || overflow !== 1'b0) begin
      fails++;
      $display("[TB] FAIL fill_full: got level=%0d wait=%0b ovf=%0b expected 16 1 0", level, cpu_wait, overflow);
    end
    tick(1, 1, 2'd3, 8'hEE, 1'b0, 8'h00);
    tests++;
    if (overflow !== 1'b1 || level !== LW'(16)) begin
      fails++;
      $display("[TB] FAIL fill_overflow: got ovf=%0b level=%0d expected 1 16", overflow, level);
    end
    n = 0;
    while (q.size() != 0 && n < 100) begin
      a = vdp_req;
      tick(0, 0, 2'd0, 8'h00, a, 8'h00);
      if (a) ack_cyc.push_back(cycle_cnt);
      n++;
    end
    tests++;
    if (ack_cyc.size() != 16) begin
      fails++;
      $display("[TB] FAIL drain_count: got %0d transfers expected 16", ack_cyc.size());
    end
    for (int i = 1; i < ack_cyc.size(); i++) begin
      tests++;
      if (ack_cyc[i] - ack_cyc[i-1] != 3) begin
        fails++;
        $display("[TB] FAIL drain_period: got %0d cycles expected 3 (transfer %0d)", ack_cyc[i] - ack_cyc[i-1], i);
      end
    end
    repeat (3) tick(0, 0, 2'd0, 8'h00, 1'b0, 8'h00);
  endtask

  task automatic test_push_on_full_pop();
    int rv;
    do_reset();
    fill(16, 8'h80);
    tests++;
    if (vdp_req !== 1'b1) begin
      fails++;
      $display("[TB] FAIL full_pop_req: got vdp_req=%0b expected 1", vdp_req);
    end
    tick(1, 1, 2'd2, 8'h77, 1'b1, 8'h00);
    tests++;
    if (level !== LW'(16) || overflow !== 1'b0) begin
      fails++;
      $display("[TB] FAIL full_pop_push: got level=%0d ovf=%0b expected 16 0", level, overflow);
    end
    drain(200, 8'h00, rv);
  endtask

  task automatic test_write_then_read();
    int rv;
    do_reset();
    tick(1, 1, 2'd1, 8'h11, 1'b0, 8'h00);
    tick(1, 1, 2'd2, 8'h22, 1'b0, 8'h00);
    tick(1, 1, 2'd3, 8'h33, 1'b0, 8'h00);
    tick(1, 0, 2'd0, 8'h00, 1'b0, 8'h00);
    drain(60, 8'h3C, rv);
    tests++;
    if (rv != 1 || cpu_rdata !== 8'h3C) begin
      fails++;
      $display("[TB] FAIL read_result: got %0d pulses data=%02h expected 1 3c", rv, cpu_rdata);
    end
  endtask

  task automatic test_double_read();
    int rv;
    do_reset();
    tick(1, 0, 2'd2, 8'h00, 1'b0, 8'h00);
    tick(1, 0, 2'd3, 8'h00, 1'b0, 8'h00);
    tests++;
    if (overflow !== 1'b1 || cpu_wait !== 1'b1) begin
      fails++;
      $display("[TB] FAIL double_read: got ovf=%0b wait=%0b expected 1 1", overflow, cpu_wait);
    end
    drain(30, 8'h5A, rv);
    tests++;
    if (rv != 1 || cpu_rdata !== 8'h5A) begin
      fails++;
      $display("[TB] FAIL double_read_rvalid: got %0d pulses data=%02h expected 1 5a", rv, cpu_rdata);
    end
  endtask

  task automatic test_reset_mid_xfer();
    int bad;
    do_reset();
    fill(5, 8'hC0);
    tests++;
    if (vdp_req !== 1'b1 || level !== LW'(5)) begin
      fails++;
      $display("[TB] FAIL mid_xfer_setup: got req=%0b level=%0d expected 1 5", vdp_req, level);
    end
    reset = 1'b1;
    @(posedge clk);
    #1;
    tests++;
    if (vdp_req !== 1'b0 || level !== '0) begin
      fails++;
      $display("[TB] FAIL mid_xfer_reset: got req=%0b level=%0d expected 0 0", vdp_req, level);
    end
    reset = 1'b0;
    model_clear();
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      tick(0, 0, 2'd0, 8'h00, (i % 3) == 0, 8'h00);
      if (vdp_req !== 1'b0) bad++;
    end
    tests++;
    if (bad != 0) begin
      fails++;
      $display("[TB] FAIL post_reset_quiet: got %0d request cycles expected 0", bad);
    end
  endtask

  task automatic test_random();
    int  rv;
    bit  req;
    bit  wr;
    bit  ack;
    for (int i = 0; i < 700; i++) begin
      req = ($urandom_range(0, 99) < 45);
      wr  = ($urandom_range(0, 99) < 75);
      ack = (vdp_req === 1'b1) ? ($urandom_range(0, 99) < 50) : ($urandom_range(0, 99) < 10);
      tick(req, wr, 2'($urandom), 8'($urandom), ack, 8'($urandom));
    end
    drain(400, 8'h99, rv);
  endtask

  initial begin
    tests     = 0;
    fails     = 0;
    cycle_cnt = 0;
    model_clear();
    test_reset();
    test_single_write();
    test_fill_overflow();
    test_push_on_full_pop();
    test_write_then_read();
    test_double_read();
    test_reset_mid_xfer();
    do_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got no completion expected finish within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
